// File: rtl/fpu_req_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpu_req_ctrl: single-outstanding host-to-FPU request/response sequencer  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fpu_req_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [63:0] req_op1,
  input  logic [63:0] req_op2,
  output logic [3:0]  fpu_cmd,
  output logic [63:0] fpu_din1,
  output logic [63:0] fpu_din2,
  output logic        fpu_dval,
  input  logic [63:0] fpu_result,
  input  logic        fpu_rdy,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_err
);

  localparam logic [15:0] TIMEOUT_CNT = TIMEOUT[15:0];
  localparam logic [1:0]  ERR_OK      = 2'b00;
  localparam logic [1:0]  ERR_ILLEGAL = 2'b01;
  localparam logic [1:0]  ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        req_ready_q;
  logic [3:0]  cmd_q, cmd_d;
  logic [63:0] din1_q, din1_d;
  logic [63:0] din2_q, din2_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic        w_accept;
  logic        w_cmd_legal;
  logic        w_req_sp;
  logic        w_cur_sp;
  logic [15:0] w_cnt_inc;
  logic [63:0] w_result;

  assign w_accept    = req_valid & req_ready_q;
  assign w_cmd_legal = ~req_cmd[3] & (|req_cmd[1:0]);
  // Bit 2 of a legal command distinguishes DP (1) from SP (0).
  assign w_req_sp    = ~req_cmd[2];
  assign w_cur_sp    = ~cmd_q[2];
  assign w_cnt_inc   = cnt_q + 16'd1;
  assign w_result    = w_cur_sp ? {32'b0, fpu_result[31:0]} : fpu_result;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    din1_d     = din1_q;
    din2_d     = din2_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          if (w_cmd_legal) begin
            cmd_d   = req_cmd;
            din1_d  = w_req_sp ? {32'b0, req_op1[31:0]} : req_op1;
            din2_d  = w_req_sp ? {32'b0, req_op2[31:0]} : req_op2;
            state_d = S_ISSUE;
          end else begin
            rsp_data_d = 64'b0;
            rsp_err_d  = ERR_ILLEGAL;
            state_d    = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        cnt_d = 16'd0;
        if (fpu_rdy) begin
          rsp_data_d = w_result;
          rsp_err_d  = ERR_OK;
          state_d    = S_RESP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = w_cnt_inc;
        // A completion in the final allowed cycle takes priority over timeout.
        if (fpu_rdy) begin
          rsp_data_d = w_result;
          rsp_err_d  = ERR_OK;
          state_d    = S_RESP;
        end else if (w_cnt_inc == TIMEOUT_CNT) begin
          rsp_data_d = 64'b0;
          rsp_err_d  = ERR_TIMEOUT;
          state_d    = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // req_ready is registered so it stays low throughout reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b0;
      cmd_q       <= 4'b0;
      din1_q      <= 64'b0;
      din2_q      <= 64'b0;
      rsp_data_q  <= 64'b0;
      rsp_err_q   <= 2'b0;
      cnt_q       <= 16'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= (state_d == S_IDLE);
      cmd_q       <= cmd_d;
      din1_q      <= din1_d;
      din2_q      <= din2_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = req_ready_q;
  assign fpu_cmd   = cmd_q;
  assign fpu_din1  = din1_q;
  assign fpu_din2  = din2_q;
  assign fpu_dval  = (state_q == S_ISSUE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: doc/fpu_req_ctrl.md
FPU_REQ_CTRL -- requirements
Module: fpu_req_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for fpu_rdy before an error response is issued (range 1-65535).
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  host request valid.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_cmd  input  4  FPU command code.
REQ-008 req_op1, req_op2  input  64 each  operands; for SP commands only bits [31:0] are used.
REQ-009 fpu_cmd  output  4  command presented to the FPU.
REQ-010 fpu_din1, fpu_din2  output  64 each  operands presented to the FPU.
REQ-011 fpu_dval  output  1  single-cycle start strobe to the FPU.
REQ-012 fpu_result  input  64  FPU result; valid only in the cycle fpu_rdy=1.
REQ-013 fpu_rdy  input  1  single-cycle FPU completion pulse.
REQ-014 rsp_valid  output  1  response valid.
REQ-015 rsp_ready  input  1  host accepts the response.
REQ-016 rsp_data  output  64  captured result.
REQ-017 rsp_err  output  2  response status: 00 ok, 01 illegal command, 10 timeout.

Function
REQ-018 The state machine SHALL have four states, IDLE, ISSUE, WAIT and RESP, one-hot or encoded.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid=1 and req_ready=1 on a rising edge.
REQ-020 Legal commands SHALL be 0001 (SP add), 0010 (SP mul), 0011 (SP div), 0101 (DP add), 0110 (DP mul) and 0111 (DP div).
REQ-021 On acceptance of a legal command, the block SHALL register the command and operands onto fpu_cmd/fpu_din1/fpu_din2 and enter ISSUE.
REQ-022 For SP commands, fpu_din1 and fpu_din2 bits [63:32] SHALL be driven to 0.
REQ-023 On acceptance of an illegal command, the block SHALL go directly to RESP with rsp_err=01 and rsp_data=0; fpu_dval SHALL never assert for that request.
REQ-024 fpu_dval SHALL be 1 for exactly one cycle, in ISSUE, which is the cycle after acceptance; the next state is WAIT.
REQ-025 fpu_cmd, fpu_din1 and fpu_din2 SHALL stay stable from ISSUE until the block leaves WAIT.
REQ-026 fpu_rdy SHALL be sampled in both ISSUE and WAIT.
REQ-027 On fpu_rdy=1, the block SHALL capture fpu_result into rsp_data, zeroing bits [63:32] for SP commands, set rsp_err=00, and enter RESP; rsp_valid is therefore 1 on the cycle after fpu_rdy.
REQ-028 A 16-bit wait counter SHALL clear on ISSUE and increment once per cycle in WAIT.
REQ-029 When the wait counter reaches TIMEOUT with fpu_rdy=0, the block SHALL enter RESP with rsp_err=10 and rsp_data=0.
REQ-030 If fpu_rdy and the timeout condition coincide, fpu_rdy SHALL win.
REQ-031 In RESP, rsp_valid=1 and rsp_data/rsp_err SHALL be held stable until rsp_ready=1, after which the block returns to IDLE on the next edge.
REQ-032 No new request SHALL be accepted in the cycle of the RESP handshake.
REQ-033 fpu_rdy asserted in IDLE or RESP SHALL be ignored and SHALL NOT alter rsp_data.
REQ-034 Only one request SHALL be outstanding at any time.

Reset
REQ-035 On rst_n=0, asynchronously: state=IDLE, req_ready=0 while rst_n=0 and 1 from the first edge after release, fpu_dval=0, fpu_cmd=0, fpu_din1=0, fpu_din2=0, rsp_valid=0, rsp_data=0, rsp_err=00, wait counter=0.
REQ-036 Reset asserted mid-operation SHALL abandon the request with no response, and a later fpu_rdy SHALL be ignored.

Verification
REQ-037 SP add, cmd=0001, op1=0x3F800000, op2=0x40000000, model rdy 3 cycles after dval with result 0x40400000 -> one dval pulse, fpu_din upper bits 0, rsp_data=0x0000000040400000, rsp_err=00.
REQ-038 DP mul, cmd=0110, op1=0x3FF8000000000000, op2=0x4000000000000000, result 0x4008000000000000 -> rsp_data=0x4008000000000000, rsp_err=00.
REQ-039 Illegal cmd=1111 -> no dval, rsp_valid on the next cycle, rsp_err=01, rsp_data=0.
REQ-040 TIMEOUT=8 with the FPU model never asserting rdy -> rsp_err=10 exactly 8 WAIT cycles after ISSUE; rdy on the 8th cycle instead -> rsp_err=00.
REQ-041 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0; a stray fpu_rdy injected during RESP leaves rsp_data unchanged.
REQ-042 rst_n pulsed low during WAIT, then a late fpu_rdy -> all outputs at reset values and no rsp_valid.
